// File: rtl/mmio_pkg.sv
// Shared definitions for the data-bus interconnect: MMIO register map,
// target select encoding and the byte-strobe merge helper.
package mmio_pkg;

  localparam int unsigned MMIO_SEL_BIT = 31;
  localparam int unsigned OFF_W        = 6;
  localparam int unsigned HEX_W        = 7;
  localparam int unsigned LED_W        = 10;
  localparam int unsigned SW_W         = 10;
  localparam int unsigned KEY_W        = 4;

  // Word offsets, i.e. d_address[7:2] (byte offset / 4)
  localparam logic [OFF_W-1:0] OFF_LED    = 6'h00;
  localparam logic [OFF_W-1:0] OFF_HEX03  = 6'h01;
  localparam logic [OFF_W-1:0] OFF_HEX45  = 6'h02;
  localparam logic [OFF_W-1:0] OFF_SW     = 6'h03;
  localparam logic [OFF_W-1:0] OFF_KEY    = 6'h04;
  localparam logic [OFF_W-1:0] OFF_TCOUNT = 6'h05;
  localparam logic [OFF_W-1:0] OFF_TCMP   = 6'h06;
  localparam logic [OFF_W-1:0] OFF_TSTAT  = 6'h07;

  localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

  typedef enum logic {TGT_RAM = 1'b0, TGT_MMIO = 1'b1} tgt_t;

  // Replace the strobed bytes of cur with the matching bytes of wdata
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: 32-bit counter, compare register and a sticky
// match flag with write-1-to-clear; all bus writes are byte-strobed.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        stat_we,
  output logic [31:0] tcount,
  output logic [31:0] tcmp,
  output logic        match
);

  // A counter write replaces the increment; unstrobed bytes hold, not count
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      tcount <= '0;
      tcmp   <= '1;
      match  <= 1'b0;
    end else begin
      tcount <= cnt_we ? merge_bytes(tcount, wdata, wstrb) : tcount + 32'd1;
      if (cmp_we) tcmp <= merge_bytes(tcmp, wdata, wstrb);
      if (tcount == tcmp)                        match <= 1'b1;
      else if (stat_we && wstrb[0] && wdata[0])  match <= 1'b0;
    end
  end

endmodule

// File: rtl/dbus_mmio.sv
// Data-bus interconnect: decodes core data accesses to RAM or the MMIO
// register file (LEDs, HEX digits, switches, keys, timer) and muxes responses.
module dbus_mmio
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 10
)
(
  input  logic               clock_50,
  input  logic               reset_n,
  input  logic [31:0]        d_address,
  input  logic [31:0]        d_data_write,
  input  logic               d_write_enable,
  input  logic [3:0]         d_data_wstrb,
  output logic [31:0]        d_data_read,
  output logic               d_data_valid,
  output logic [31:0]        ram_addr,
  output logic [31:0]        ram_wdata,
  output logic               ram_we,
  output logic [3:0]         ram_wstrb,
  input  logic [31:0]        ram_rdata,
  input  logic               ram_rdata_valid,
  input  logic [SW_W-1:0]    sw,
  input  logic [KEY_W-1:0]   key,
  output logic [LED_W-1:0]   ledr,
  output logic [HEX_W-1:0]   hex0,
  output logic [HEX_W-1:0]   hex1,
  output logic [HEX_W-1:0]   hex2,
  output logic [HEX_W-1:0]   hex3,
  output logic [HEX_W-1:0]   hex4,
  output logic [HEX_W-1:0]   hex5
);

  tgt_t             tgt_c;
  tgt_t             tgt_q;
  logic [OFF_W-1:0] off_c;
  logic             mmio_wr_c;
  logic [31:0]      mmio_rdata_c;
  logic [31:0]      mmio_rdata_q;
  logic             resp_live_q;

  logic [SW_W-1:0]  sw_meta, sw_sync;
  logic [KEY_W-1:0] key_meta, key_sync;
  logic [HEX_W-1:0] hex_q [6];

  logic [31:0]      t_count, t_cmp;
  logic             t_match;

  // Decode
  assign tgt_c     = d_address[MMIO_SEL_BIT] ? TGT_MMIO : TGT_RAM;
  assign off_c     = d_address[7:2];
  assign mmio_wr_c = d_write_enable & (tgt_c == TGT_MMIO) & (|d_data_wstrb);

  // RAM pass-through; accesses past the RAM size alias, there is no fault path
  assign ram_addr  = d_address;
  assign ram_wdata = d_data_write;
  assign ram_wstrb = d_data_wstrb;
  assign ram_we    = d_write_enable & (tgt_c == TGT_RAM) & (|d_data_wstrb);

  logic unused_ram_oob;
  assign unused_ram_oob = ({1'b0, d_address[30:0]} >= (32'd4 << RAM_ADDR_WIDTH));

  // Two-flop synchronisers; keys are stored inverted so 1 means pressed
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      key_meta <= ~key;
      key_sync <= key_meta;
    end
  end

  // LED and HEX registers
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      ledr <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= HEX_BLANK;
    end else if (mmio_wr_c) begin
      case (off_c)
        OFF_LED: begin
          if (d_data_wstrb[0]) ledr[7:0] <= d_data_write[7:0];
          if (d_data_wstrb[1]) ledr[9:8] <= d_data_write[9:8];
        end
        OFF_HEX03: begin
          for (int i = 0; i < 4; i++)
            if (d_data_wstrb[i]) hex_q[i] <= d_data_write[8*i +: HEX_W];
        end
        OFF_HEX45: begin
          for (int i = 0; i < 2; i++)
            if (d_data_wstrb[i]) hex_q[4+i] <= d_data_write[8*i +: HEX_W];
        end
        default: ;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

  mmio_timer u_timer (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .wdata    (d_data_write),
    .wstrb    (d_data_wstrb),
    .cnt_we   (mmio_wr_c && (off_c == OFF_TCOUNT)),
    .cmp_we   (mmio_wr_c && (off_c == OFF_TCMP)),
    .stat_we  (mmio_wr_c && (off_c == OFF_TSTAT)),
    .tcount   (t_count),
    .tcmp     (t_cmp),
    .match    (t_match)
  );

  // MMIO read mux; unmapped offsets and reserved bits read 0
  always_comb begin
    mmio_rdata_c = '0;
    case (off_c)
      OFF_LED:    mmio_rdata_c = {22'd0, ledr};
      OFF_HEX03:  mmio_rdata_c = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
      OFF_HEX45:  mmio_rdata_c = {17'd0, hex_q[5], 1'b0, hex_q[4]};
      OFF_SW:     mmio_rdata_c = {22'd0, sw_sync};
      OFF_KEY:    mmio_rdata_c = {28'd0, key_sync};
      OFF_TCOUNT: mmio_rdata_c = t_count;
      OFF_TCMP:   mmio_rdata_c = t_cmp;
      OFF_TSTAT:  mmio_rdata_c = {31'd0, t_match};
      default:    mmio_rdata_c = '0;
    endcase
  end

  // Every cycle is an access; register its target and MMIO data for the response
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      resp_live_q  <= 1'b0;
      tgt_q        <= TGT_RAM;
      mmio_rdata_q <= '0;
    end else begin
      resp_live_q  <= 1'b1;
      tgt_q        <= tgt_c;
      mmio_rdata_q <= mmio_rdata_c;
    end
  end

  // Response mux; RAM data and valid pass straight through
  always_comb begin
    d_data_read  = '0;
    d_data_valid = 1'b0;
    if (resp_live_q) begin
      if (tgt_q == TGT_MMIO) begin
        d_data_read  = mmio_rdata_q;
        d_data_valid = 1'b1;
      end else begin
        d_data_read  = ram_rdata;
        d_data_valid = ram_rdata_valid;
      end
    end
  end

endmodule
